halt_controller: RTL and testbench
==================================

# halt_controller

Low-power sequencer between the CPU's HALTCNT register write and the interrupt controller. It stalls the CPU core on a HALTCNT write. In stop mode it also gates the LCD and sound blocks. It wakes the core when an enabled interrupt becomes pending (IE & IF, independent of IME), applying a programmable wake-up latency. It also keeps a halted-cycle counter for debug.

## Interface
- `WAKE_CYCLES`, default 4: cycles spent in WAKE after a halt exit before `cpu_en` rises. Legal range 1..15.
- `STOP_WAKE_CYCLES`, default 15: cycles spent in WAKE after a stop exit. Legal range 1..15.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `haltcnt_wr`  in  1  single-cycle strobe: CPU writes HALTCNT
- `haltcnt_data`  in  8  write data; bit 7 = 1 requests stop, 0 requests halt; other bits ignored
- `cpu_bus_idle`  in  1  CPU has no outstanding bus access
- `reg_IE`  in  16  interrupt enable register
- `reg_IF`  in  16  interrupt flags from the interrupt controller (already IE-masked)
- `cpu_en`  out  1  CPU clock enable; reset 1
- `lcd_en`  out  1  LCD enable; reset 1
- `sound_en`  out  1  sound enable; reset 1
- `halted`  out  1  high in HALT_PEND, HALT, STOP and WAKE; reset 0
- `state`  out  3  current state encoding; reset 0 (RUN)
- `halt_cycles`  out  32  count of cycles with `cpu_en` = 0, saturates at 0xFFFF_FFFF; reset 0

## Operation
- `pending` = |(reg_IE[13:0] & reg_IF[13:0]).
- `stop_pending` = |(reg_IE & reg_IF & 14'h3080), i.e. serial (bit 7), keypad (bit 12) and game pak (bit 13) only.
- States and encodings: RUN = 0, HALT_PEND = 1, HALT = 2, STOP = 3, WAKE = 4. All other encodings return to RUN on the next cycle.
- RUN:
  - On `haltcnt_wr`, latch `is_stop` = haltcnt_data[7] and go to HALT_PEND.
  - Otherwise stay in RUN.
- HALT_PEND (CPU still running):
  - Wait until `cpu_bus_idle` = 1.
  - When idle and `is_stop` = 0: go to WAKE with the halt latency if `pending` is set, else go to HALT.
  - When idle and `is_stop` = 1: go to WAKE with the stop latency if `stop_pending` is set, else go to STOP.
- HALT:
  - `cpu_en` = 0.
  - On `pending`, go to WAKE and load the counter with WAKE_CYCLES-1.
- STOP:
  - `cpu_en`, `lcd_en` and `sound_en` all 0.
  - On `stop_pending`, go to WAKE and load the counter with STOP_WAKE_CYCLES-1.
  - `pending` from any other source is ignored.
- WAKE:
  - `cpu_en` stays 0 and `lcd_en`/`sound_en` stay as they were in the source state.
  - Decrement the counter each cycle; at 0, go to RUN.
- Counter is 4 bits wide.
- `haltcnt_wr` in any state other than RUN is ignored.
- `halt_cycles` increments on every cycle in which the registered `cpu_en` = 0, and holds at its maximum value.
- All outputs are registered and decoded from the next state.

## Timing
- Entry: `haltcnt_wr` at cycle N puts the block in HALT_PEND at N+1. If `cpu_bus_idle` = 1 at N+1, the block is in HALT/STOP at N+2 and `cpu_en` = 0 from N+2.
- Exit: `pending` sampled high at cycle M in HALT puts the block in WAKE at M+1. `cpu_en` = 1 and state = RUN at M+1+WAKE_CYCLES (stop exits use STOP_WAKE_CYCLES).
- Immediate exit: with an interrupt already pending at entry, HALT_PEND goes directly to WAKE and `cpu_en` never drops.
- `pending` deasserting during WAKE does not abort the wake.
- Reset asserted in any state forces RUN and all outputs to their reset values asynchronously, including clearing `halt_cycles`.

## Configuration
- `GBA_STOP_MODE_EN` defined: stop mode behaves as described above.
- Undefined:
  - Bit 7 is ignored and every write is treated as halt.
  - STOP is unreachable; an illegal encoding 3 returns to RUN.
  - `lcd_en` and `sound_en` are tied to 1.
  - STOP_WAKE_CYCLES is unused.

## Test plan
- Halt then vblank: reset, IE=0x0001, `cpu_bus_idle`=1, write 0x00 at cycle 10 -> `cpu_en`=0 from cycle 12. Assert IF=0x0001 at cycle 50 -> state WAKE at 51, `cpu_en`=1 and state RUN at 55 (WAKE_CYCLES=4). `halt_cycles`=43.
- Bus busy: write 0x00 with `cpu_bus_idle`=0 for 5 cycles -> state stays 1 and `cpu_en` stays 1. Idle at cycle K -> HALT at K+1.
- Pending at entry: IE=IF=0x0008, write 0x00 -> state 1 then 4, `cpu_en` never 0, back in RUN 4 cycles after entering WAKE.
- Stop wake source (GBA_STOP_MODE_EN defined): IE=0x1001, write 0x80 -> `lcd_en`=`sound_en`=`cpu_en`=0. IF=0x0001 -> remains STOP. IF=0x1000 -> WAKE, RUN after 15 cycles; `lcd_en`=1 on return to RUN.
- Macro off: write 0x80 with IE=0x0001 -> state HALT (2), `lcd_en` stays 1. IF=0x0001 wakes it.
- Reset mid-WAKE: assert reset during WAKE -> state 0, `cpu_en`=1, `halted`=0, `halt_cycles`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/halt_controller.sv
// halt_controller: HALTCNT halt/stop sequencer with programmable wake latency; stop mode enabled by GBA_STOP_MODE_EN
module halt_controller #(
    parameter int WAKE_CYCLES      = 4,
    parameter int STOP_WAKE_CYCLES = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        haltcnt_wr,
    input  logic [7:0]  haltcnt_data,
    input  logic        cpu_bus_idle,
    input  logic [15:0] reg_IE,
    input  logic [15:0] reg_IF,
    output logic        cpu_en,
    output logic        lcd_en,
    output logic        sound_en,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] halt_cycles
);
    localparam logic [2:0] RUN = 3'd0, HALT_PEND = 3'd1, HALT = 3'd2, STOP = 3'd3, WAKE = 3'd4;
    localparam logic [3:0] WAKE_LOAD = 4'(WAKE_CYCLES - 1);
    localparam logic [3:0] STOP_LOAD = 4'(STOP_WAKE_CYCLES - 1);
    logic [2:0] next_state;
    logic [3:0] cnt, next_cnt;
    logic       is_stop, wr_stop, pending, stop_pending, next_cpu_en, next_halted;
    logic       unused_hi;
    assign pending   = |(reg_IE[13:0] & reg_IF[13:0]);
    assign unused_hi = ^{haltcnt_data[6:0], reg_IE[15:14], reg_IF[15:14]};
`ifdef GBA_STOP_MODE_EN
    logic next_lcd_en;
    assign stop_pending = |(reg_IE[13:0] & reg_IF[13:0] & 14'h3080);
    assign wr_stop      = haltcnt_data[7];
    // LCD and sound keep their source-state value through WAKE
    assign next_lcd_en  = next_state == WAKE ? lcd_en : next_state != STOP;
    always_ff @(posedge clock or posedge reset)
        if (reset) lcd_en <= 1'b1;
        else lcd_en <= next_lcd_en;
    assign sound_en = lcd_en;
`else
    logic unused_stop;
    assign stop_pending = 1'b0;
    assign wr_stop      = 1'b0;
    assign unused_stop  = haltcnt_data[7];
    assign lcd_en       = 1'b1;
    assign sound_en     = 1'b1;
`endif
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            is_stop     <= 1'b0;
            cpu_en      <= 1'b1;
            halted      <= 1'b0;
            halt_cycles <= 32'd0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            is_stop     <= (state == RUN && haltcnt_wr) ? wr_stop : is_stop;
            cpu_en      <= next_cpu_en;
            halted      <= next_halted;
            halt_cycles <= (!cpu_en && halt_cycles != 32'hFFFF_FFFF) ? halt_cycles + 32'd1 : halt_cycles;
        end
    always_comb begin
        next_state = RUN;
        next_cnt   = cnt;
        case (state)
            RUN: next_state = haltcnt_wr ? HALT_PEND : RUN;
            HALT_PEND: begin
                next_state = !cpu_bus_idle ? HALT_PEND
                           : is_stop ? (stop_pending ? WAKE : STOP)
                           : (pending ? WAKE : HALT);
                next_cnt   = is_stop ? STOP_LOAD : WAKE_LOAD;
            end
            HALT: begin
                next_state = pending ? WAKE : HALT;
                next_cnt   = WAKE_LOAD;
            end
`ifdef GBA_STOP_MODE_EN
            STOP: begin
                next_state = stop_pending ? WAKE : STOP;
                next_cnt   = STOP_LOAD;
            end
`endif
            WAKE: begin
                next_state = cnt == 4'd0 ? RUN : WAKE;
                next_cnt   = cnt - 4'd1;
            end
            default: next_state = RUN;
        endcase
    end
    // an immediate exit from HALT_PEND keeps the CPU running through WAKE
    always_comb begin
        next_cpu_en = next_state == WAKE ? cpu_en : !(next_state == HALT || next_state == STOP);
        next_halted = next_state != RUN;
    end
endmodule

// File: tb/tb_halt_controller.sv
// tb_halt_controller: vector table, directed corner sequences and randomized comparison with a reference model
module tb_halt_controller;
    localparam int WC  = 4;
    localparam int SWC = 15;
`ifdef GBA_STOP_MODE_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif
    logic        clock = 1'b0, reset = 1'b1, haltcnt_wr = 1'b0, cpu_bus_idle = 1'b1;
    logic [7:0]  haltcnt_data = 8'h00;
    logic [15:0] reg_IE = 16'h0, reg_IF = 16'h0;
    logic        cpu_en, lcd_en, sound_en, halted;
    logic [2:0]  state;
    logic [31:0] halt_cycles;
    int          tests = 0, fails = 0;

    always #5 clock = ~clock;

    halt_controller #(.WAKE_CYCLES(WC), .STOP_WAKE_CYCLES(SWC)) dut (
        .clock(clock), .reset(reset), .haltcnt_wr(haltcnt_wr), .haltcnt_data(haltcnt_data),
        .cpu_bus_idle(cpu_bus_idle), .reg_IE(reg_IE), .reg_IF(reg_IF), .cpu_en(cpu_en),
        .lcd_en(lcd_en), .sound_en(sound_en), .halted(halted), .state(state), .halt_cycles(halt_cycles)
    );

    int     m_state, m_left;
    bit     m_stop, m_cpu, m_lcd;
    longint m_hc;

    task automatic model_reset();
        m_state = 0; m_left = 0; m_stop = 0; m_cpu = 1; m_lcd = 1; m_hc = 0;
    endtask

    task automatic model_step();
        bit pend, spend;
        pend  = |(reg_IE[13:0] & reg_IF[13:0]);
        spend = |(reg_IE & reg_IF & 16'h3080);
        if (!m_cpu && m_hc < 64'hFFFF_FFFF) m_hc++;
        case (m_state)
            0: if (haltcnt_wr) begin m_state = 1; m_stop = STOP_EN && haltcnt_data[7]; end
            1: if (cpu_bus_idle) begin
                if (m_stop) begin
                    if (spend) begin m_state = 4; m_left = SWC; end else m_state = 3;
                end else begin
                    if (pend) begin m_state = 4; m_left = WC; end else m_state = 2;
                end
            end
            2: if (pend) begin m_state = 4; m_left = WC; end
            3: if (spend) begin m_state = 4; m_left = SWC; end
            default: begin m_left--; if (m_left == 0) m_state = 0; end
        endcase
        if (m_state != 4) begin m_cpu = m_state < 2; m_lcd = m_state != 3; end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; haltcnt_wr = 1'b0; haltcnt_data = 8'h00;
        reg_IE = 16'h0; reg_IF = 16'h0; cpu_bus_idle = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit wr; logic [7:0] data; bit idle; logic [15:0] ie; logic [15:0] ifl;
        logic [2:0] st; bit cpu; bit lcd; bit hal;
    } vec_t;
    vec_t vt[18];

    initial begin
        vt[0]  = '{1'b1, 8'h00, 1'b0, 16'h0001, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 8'h00, 1'b0, 16'h0001, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b1};
        vt[2]  = vt[1];
        vt[3]  = vt[1];
        vt[4]  = vt[1];
        vt[5]  = '{1'b0, 8'h00, 1'b1, 16'h0001, 16'h0000, 3'd2, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 8'h00, 1'b1, 16'h0001, 16'h0000, 3'd2, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 16'h0001, 16'h0001, 3'd4, 1'b0, 1'b1, 1'b1};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 16'h0001, 16'h0000, 3'd4, 1'b0, 1'b1, 1'b1};
        vt[9]  = vt[8];
        vt[10] = vt[8];
        vt[11] = '{1'b0, 8'h00, 1'b1, 16'h0001, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
        vt[12] = '{1'b1, 8'h00, 1'b1, 16'h0008, 16'h0008, 3'd1, 1'b1, 1'b1, 1'b1};
        vt[13] = '{1'b0, 8'h00, 1'b1, 16'h0008, 16'h0008, 3'd4, 1'b1, 1'b1, 1'b1};
        vt[14] = vt[13];
        vt[15] = vt[13];
        vt[16] = vt[13];
        vt[17] = '{1'b0, 8'h00, 1'b1, 16'h0008, 16'h0008, 3'd0, 1'b1, 1'b1, 1'b0};

        do_reset();
        chk("reset_state", state, 3'd0);
        chk("reset_cpu_en", cpu_en, 1'b1);
        chk("reset_lcd_en", lcd_en, 1'b1);
        chk("reset_sound_en", sound_en, 1'b1);
        chk("reset_halted", halted, 1'b0);
        chk("reset_halt_cycles", halt_cycles, 32'd0);

        for (int i = 0; i < 18; i++) begin
            haltcnt_wr = vt[i].wr; haltcnt_data = vt[i].data; cpu_bus_idle = vt[i].idle;
            reg_IE = vt[i].ie; reg_IF = vt[i].ifl;
            tick();
            chk($sformatf("vec%0d_state", i), state, vt[i].st);
            chk($sformatf("vec%0d_cpu_en", i), cpu_en, vt[i].cpu);
            chk($sformatf("vec%0d_lcd_en", i), lcd_en, vt[i].lcd);
            chk($sformatf("vec%0d_sound_en", i), sound_en, vt[i].lcd);
            chk($sformatf("vec%0d_halted", i), halted, vt[i].hal);
        end
        chk("vec_halt_cycles", halt_cycles, 32'd6);

        // halt then vblank with absolute cycle numbers
        do_reset();
        reg_IE = 16'h0001; cpu_bus_idle = 1'b1;
        repeat (9) tick();
        haltcnt_wr = 1'b1; tick(); haltcnt_wr = 1'b0;
        chk("vbl_pend_state", state, 3'd1);
        tick();
        chk("vbl_c12_state", state, 3'd2);
        chk("vbl_c12_cpu_en", cpu_en, 1'b0);
        repeat (38) tick();
        chk("vbl_c50_state", state, 3'd2);
        reg_IF = 16'h0001; tick(); reg_IF = 16'h0000;
        chk("vbl_c51_state", state, 3'd4);
        chk("vbl_c51_cpu_en", cpu_en, 1'b0);
        repeat (3) tick();
        chk("vbl_c54_state", state, 3'd4);
        tick();
        chk("vbl_c55_state", state, 3'd0);
        chk("vbl_c55_cpu_en", cpu_en, 1'b1);
        chk("vbl_halt_cycles", halt_cycles, 32'd43);

`ifdef GBA_STOP_MODE_EN
        do_reset();
        reg_IE = 16'h1001; haltcnt_data = 8'h80; haltcnt_wr = 1'b1; tick(); haltcnt_wr = 1'b0;
        chk("stop_pend_state", state, 3'd1);
        tick();
        chk("stop_state", state, 3'd3);
        chk("stop_cpu_en", cpu_en, 1'b0);
        chk("stop_lcd_en", lcd_en, 1'b0);
        chk("stop_sound_en", sound_en, 1'b0);
        reg_IF = 16'h0001; repeat (5) tick();
        chk("stop_ignore_vbl", state, 3'd3);
        reg_IF = 16'h1000; tick(); reg_IF = 16'h0000;
        chk("stop_wake_state", state, 3'd4);
        chk("stop_wake_lcd_en", lcd_en, 1'b0);
        repeat (14) tick();
        chk("stop_wake_last", state, 3'd4);
        tick();
        chk("stop_run_state", state, 3'd0);
        chk("stop_run_cpu_en", cpu_en, 1'b1);
        chk("stop_run_lcd_en", lcd_en, 1'b1);
        chk("stop_run_sound_en", sound_en, 1'b1);
`else
        do_reset();
        reg_IE = 16'h0001; haltcnt_data = 8'h80; haltcnt_wr = 1'b1; tick(); haltcnt_wr = 1'b0;
        chk("nostop_pend_state", state, 3'd1);
        tick();
        chk("nostop_state", state, 3'd2);
        chk("nostop_lcd_en", lcd_en, 1'b1);
        chk("nostop_sound_en", sound_en, 1'b1);
        reg_IF = 16'h0001; tick(); reg_IF = 16'h0000;
        chk("nostop_wake_state", state, 3'd4);
        repeat (3) tick();
        chk("nostop_wake_last", state, 3'd4);
        tick();
        chk("nostop_run_state", state, 3'd0);
`endif

        // asynchronous reset in the middle of WAKE
        do_reset();
        reg_IE = 16'h0001; haltcnt_wr = 1'b1; tick(); haltcnt_wr = 1'b0;
        tick();
        reg_IF = 16'h0001; tick(); reg_IF = 16'h0000;
        tick();
        chk("arst_pre_state", state, 3'd4);
        chk("arst_pre_halt_cycles", halt_cycles, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_state", state, 3'd0);
        chk("arst_cpu_en", cpu_en, 1'b1);
        chk("arst_halted", halted, 1'b0);
        chk("arst_halt_cycles", halt_cycles, 32'd0);
        chk("arst_lcd_en", lcd_en, 1'b1);

        do_reset();
        for (int c = 0; c < 5000; c++) begin
            if ($urandom % 64 == 0)
                case ($urandom % 5)
                    0: reg_IE = 16'h0001;
                    1: reg_IE = 16'h1001;
                    2: reg_IE = 16'h2080;
                    3: reg_IE = 16'hFFFF;
                    default: reg_IE = 16'hC000;
                endcase
            if ($urandom % 10 == 0) reg_IF = ($urandom % 3 == 0) ? 16'(1 << ($urandom % 16)) : 16'h0000;
            haltcnt_wr   = ($urandom % 20 == 0);
            haltcnt_data = 8'($urandom);
            cpu_bus_idle = ($urandom % 4 != 0);
            tick();
            chk($sformatf("rand_cyc%0d", c), {state, cpu_en, lcd_en, sound_en, halted, halt_cycles},
                {3'(m_state), m_cpu, m_lcd, m_lcd, m_state != 0, 32'(m_hc)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
